fixed_accumulator: RTL and testbench

//  Saturating signed fixed-point accumulator between float2fixed and fixed2float.

---
 rtl/fixed_pkg.sv | 16 +
 rtl/fixed_accumulator_if.sv | 37 +++
 rtl/fixed_sat_add.sv | 38 +++
 rtl/fixed_accumulator.sv | 112 +++++++++++
 tb/tb_fixed_accumulator.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point domain types and constants for the float16 accumulate path.
// Two's complement words use a symmetric range; the most negative code is never produced.
package fixed_pkg;
    localparam int FIXED_W = 43;

    typedef logic signed [FIXED_W-1:0] fixed_t;

    localparam fixed_t FIXED_MAX     = {1'b0, {(FIXED_W-1){1'b1}}};
    localparam fixed_t FIXED_MIN_SYM = {1'b1, {(FIXED_W-2){1'b0}}, 1'b1};
    localparam fixed_t FIXED_MIN_RAW = {1'b1, {(FIXED_W-1){1'b0}}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } acc_state_t;
endpackage

// File: rtl/fixed_accumulator_if.sv
// Beat-in / result-out bundle of the fixed accumulator.
// Optional out_ovf present when FIXED_ACC_OVF_FLAG_EN is defined.
interface fixed_accumulator_if #(
    parameter int CNT_W = 9
);
    import fixed_pkg::*;

    logic             in_valid;
    logic             in_ready;
    fixed_t           in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    fixed_t           out_data;
    logic [CNT_W-1:0] out_count;
`ifdef FIXED_ACC_OVF_FLAG_EN
    logic             out_ovf;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_ovf
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count, out_ovf
    );
`else
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_count
    );
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_count
    );
`endif
endinterface

// File: rtl/fixed_sat_add.sv
// Combinational saturating adder for the symmetric fixed-point domain.
// ovf flags any clamped operand or clipped sum.
module fixed_sat_add
    import fixed_pkg::*;
(
    input  fixed_t a,
    input  fixed_t b,
    output fixed_t sum,
    output logic   ovf
);
    typedef logic signed [FIXED_W:0] wide_t;

    function automatic fixed_t clamp_in(input fixed_t v);
        return (v == FIXED_MIN_RAW) ? FIXED_MIN_SYM : v;
    endfunction

    // Clipping on the full-width sum also catches a result of exactly -2**(FIXED_W-1)
    function automatic fixed_t sat_clip(input wide_t w);
        if (w > wide_t'(FIXED_MAX))
            return FIXED_MAX;
        else if (w < wide_t'(FIXED_MIN_SYM))
            return FIXED_MIN_SYM;
        else
            return fixed_t'(w);
    endfunction

    fixed_t a_c;
    fixed_t b_c;
    wide_t  wide;

    always_comb begin
        a_c  = clamp_in(a);
        b_c  = clamp_in(b);
        wide = wide_t'(a_c) + wide_t'(b_c);
        sum  = sat_clip(wide);
        ovf  = (a != a_c) | (b != b_c) | (wide != wide_t'(sum));
    end
endmodule

// File: rtl/fixed_accumulator.sv
// Saturating signed accumulator: sums a group of fixed-point beats and emits one result per group.
// Define FIXED_ACC_OVF_FLAG_EN to add the per-group saturation flag out_ovf.
module fixed_accumulator
    import fixed_pkg::*;
#(
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 9
) (
    input  logic                clk,
    input  logic                reset,
    fixed_accumulator_if.slave  bus
);
    acc_state_t       state;
    acc_state_t       state_nxt;
    fixed_t           acc;
    fixed_t           add_b;
    fixed_t           sum;
    logic             add_ovf;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             beat;
    logic             close;
    logic             first_beat;
    logic             out_valid_r;
    fixed_t           out_data_r;
    logic [CNT_W-1:0] out_count_r;

    // Result register frees in the same cycle it is consumed
    assign bus.in_ready  = ~out_valid_r | bus.out_ready;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_count = out_count_r;

    assign beat    = bus.in_valid & bus.in_ready;
    assign cnt_inc = beat_cnt + CNT_W'(1);
    assign close   = bus.in_last | (cnt_inc == CNT_W'(MAX_BEATS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (beat)
            state_nxt = close ? IDLE : ACCUM;
    end

    always_comb begin
        first_beat = (state == IDLE);
        add_b      = first_beat ? '0 : acc;
    end

    fixed_sat_add u_sat_add (
        .a   (bus.in_data),
        .b   (add_b),
        .sum (sum),
        .ovf (add_ovf)
    );

    // Accumulate stage / result register boundary
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc         <= '0;
            beat_cnt    <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_count_r <= '0;
        end else begin
            if (out_valid_r & bus.out_ready)
                out_valid_r <= 1'b0;
            if (beat) begin
                if (close) begin
                    out_valid_r <= 1'b1;
                    out_data_r  <= sum;
                    out_count_r <= cnt_inc;
                    acc         <= '0;
                    beat_cnt    <= '0;
                end else begin
                    acc         <= sum;
                    beat_cnt    <= cnt_inc;
                end
            end
        end
    end

`ifdef FIXED_ACC_OVF_FLAG_EN
    logic grp_ovf;
    logic out_ovf_r;

    assign bus.out_ovf = out_ovf_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grp_ovf   <= 1'b0;
            out_ovf_r <= 1'b0;
        end else if (beat) begin
            if (close) begin
                grp_ovf   <= 1'b0;
                out_ovf_r <= grp_ovf | add_ovf;
            end else begin
                grp_ovf   <= grp_ovf | add_ovf;
            end
        end
    end
`else
    logic ovf_unused;
    assign ovf_unused = add_ovf;
`endif
endmodule

// File: tb/tb_fixed_accumulator.sv
// Directed self-checking bench for fixed_accumulator with hand-computed expected sums.
module tb_fixed_accumulator;
    import fixed_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    fixed_accumulator_if #(.CNT_W(9)) bus ();

    fixed_accumulator #(.MAX_BEATS(256), .CNT_W(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic send(input fixed_t d, input logic last);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.in_ready)
            chk("ready_timeout", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        #1 reset = 1'b1;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data",  64'(bus.out_data),  64'd0);
        chk("rst_count", 64'(bus.out_count), 64'd0);
        chk("rst_ready", 64'(bus.in_ready),  64'd1);
        @(posedge clk); #1;
        reset = 1'b0;

        // 5 - 3 + 10 = 12
        send(fixed_t'(5), 1'b0);
        send(fixed_t'(-3), 1'b0);
        chk("t1_latency", 64'(bus.out_valid), 64'd0);
        send(fixed_t'(10), 1'b1);
        chk("t1_valid", 64'(bus.out_valid), 64'd1);
        chk("t1_data",  64'(bus.out_data),  64'(fixed_t'(12)));
        chk("t1_count", 64'(bus.out_count), 64'd3);
`ifdef FIXED_ACC_OVF_FLAG_EN
        chk("t1_ovf", 64'(bus.out_ovf), 64'd0);
`endif
        @(posedge clk); #1;
        chk("t1_drain", 64'(bus.out_valid), 64'd0);

        send(FIXED_MAX, 1'b0);
        send(fixed_t'(1), 1'b1);
        chk("t2_data",  64'(bus.out_data),  64'(FIXED_MAX));
        chk("t2_count", 64'(bus.out_count), 64'd2);
`ifdef FIXED_ACC_OVF_FLAG_EN
        chk("t2_ovf", 64'(bus.out_ovf), 64'd1);
`endif

        send(FIXED_MIN_SYM, 1'b0);
        send(fixed_t'(-1), 1'b1);
        chk("t3_negsat", 64'(bus.out_data), 64'(FIXED_MIN_SYM));
        send(FIXED_MIN_RAW, 1'b1);
        chk("t3_clamp",  64'(bus.out_data),  64'(FIXED_MIN_SYM));
        chk("t3_count",  64'(bus.out_count), 64'd1);
`ifdef FIXED_ACC_OVF_FLAG_EN
        chk("t3_ovf", 64'(bus.out_ovf), 64'd1);
`endif
        @(posedge clk); #1;

        // Stall: pending result of 1 blocks a beat of 4, which must be taken exactly once
        bus.out_ready = 1'b0;
        send(fixed_t'(1), 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = fixed_t'(4);
        bus.in_last  = 1'b0;
        #1;
        chk("t4_stall_rdy", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("t4_hold_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_hold_data",  64'(bus.out_data),  64'(fixed_t'(1)));
        chk("t4_hold_rdy",   64'(bus.in_ready),  64'd0);
        bus.out_ready = 1'b1;
        #1;
        chk("t4_release_rdy", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        chk("t4_taken", 64'(bus.out_valid), 64'd0);
        bus.in_data = fixed_t'(5);
        bus.in_last = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        chk("t4_valid", 64'(bus.out_valid), 64'd1);
        chk("t4_data",  64'(bus.out_data),  64'(fixed_t'(9)));
        chk("t4_count", 64'(bus.out_count), 64'd2);

        for (int i = 0; i < 255; i++)
            send(fixed_t'(1), 1'b0);
        chk("t5_pre", 64'(bus.out_valid), 64'd0);
        send(fixed_t'(1), 1'b0);
        chk("t5_valid", 64'(bus.out_valid), 64'd1);
        chk("t5_data",  64'(bus.out_data),  64'(fixed_t'(256)));
        chk("t5_count", 64'(bus.out_count), 64'd256);
        send(fixed_t'(2), 1'b1);
        chk("t5_next_data",  64'(bus.out_data),  64'(fixed_t'(2)));
        chk("t5_next_count", 64'(bus.out_count), 64'd1);

        // Async reset mid-group: partial 3+4 is discarded
        send(fixed_t'(3), 1'b0);
        send(fixed_t'(4), 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(bus.out_valid), 64'd0);
        chk("t6_rst_data",  64'(bus.out_data),  64'd0);
        chk("t6_rst_count", 64'(bus.out_count), 64'd0);
        chk("t6_rst_ready", 64'(bus.in_ready),  64'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        send(fixed_t'(7), 1'b1);
        chk("t6_data",  64'(bus.out_data),  64'(fixed_t'(7)));
        chk("t6_count", 64'(bus.out_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
